// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer above the datapath control FSM
//   clk, reset_n    : clock (rising edge), asynchronous active-low reset
//   run             : keep executing while high; sampled in IDLE and at retire
//   mem_addr/mem_rd : fetch address (= pc) and read request, held until mem_ready
//   mem_ready/mem_rdata : read accept and instruction word, valid together
//   ir              : instruction register feeding datapath decode
//   dp_start/dp_w   : start pulse to the datapath FSM, its idle flag back
//   pc, busy, halted, instr_count : status outputs
module fetch_ctrl #(
  parameter int PC_W = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic            mem_ready,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     ir,
  output logic            dp_start,
  input  logic            dp_w,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     instr_count
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] ISSUE  = 3'd2;
  localparam logic [2:0] ACK    = 3'd3;
  localparam logic [2:0] EXEC   = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;
  logic [2:0] state, next;
  logic       is_halt;
  assign is_halt = ir[15:13] == 3'b111;
  // ACK waits for the datapath to leave idle so a stale dp_w = 1 is not
  // mistaken for completion; EXEC then waits for it to return.
  always_comb
    next = (state == IDLE)   ? (run ? FETCH : IDLE) :
           (state == FETCH)  ? (mem_ready ? ISSUE : FETCH) :
           (state == ISSUE)  ? (is_halt ? HALTED : ACK) :
           (state == ACK)    ? (dp_w ? ACK : EXEC) :
           (state == EXEC)   ? (dp_w ? (run ? FETCH : IDLE) : EXEC) :
           (state == HALTED) ? HALTED : IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      state <= next;
      if (state == FETCH && mem_ready) ir <= mem_rdata;
      if (state == ISSUE && !is_halt) pc <= pc + 1'b1;
      if (state == EXEC && dp_w) instr_count <= instr_count + 16'd1;
    end
  // Outputs decode only registered state, so reset clears them with no edge.
  assign mem_addr = pc;
  assign mem_rd   = state == FETCH;
  assign dp_start = state == ISSUE && !is_halt;
  assign busy     = !(state == IDLE || state == HALTED);
  assign halted   = state == HALTED;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        run = 1'b0;
  logic        rdy = 1'b1;
  logic [8:0]  mem_addr, w_addr, pc, w_pc;
  logic        mem_rd, w_rd, dp_start, w_start, busy, w_busy, halted, w_halted;
  logic [15:0] mem_rdata, w_rdata, ir, w_ir, instr_count, w_count;
  logic        dp_w;
  logic [2:0]  dcnt;
  logic [15:0] prog [0:511];
  logic [15:0] exp_q [$];
  int          vecs = 0;
  int          errs = 0;
  int          nstart = 0;
  int          nrd = 0;
  int          s0, r0;

  fetch_ctrl #(.PC_W(9), .RESET_PC(9'd0)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ready(rdy), .mem_rdata(mem_rdata), .ir(ir), .dp_start(dp_start), .dp_w(dp_w),
    .pc(pc), .busy(busy), .halted(halted), .instr_count(instr_count));

  fetch_ctrl #(.PC_W(9), .RESET_PC(9'd511)) u_wrap (
    .clk(clk), .reset_n(reset_n), .run(run), .mem_addr(w_addr), .mem_rd(w_rd),
    .mem_ready(rdy), .mem_rdata(w_rdata), .ir(w_ir), .dp_start(w_start), .dp_w(dp_w),
    .pc(w_pc), .busy(w_busy), .halted(w_halted), .instr_count(w_count));

  always #5 clk = ~clk;

  assign mem_rdata = prog[mem_addr];
  assign w_rdata   = prog[w_addr];

  always @(posedge clk or negedge reset_n)
    if (!reset_n) dcnt <= 3'd0;
    else if (dp_start) dcnt <= 3'd4;
    else if (dcnt != 3'd0) dcnt <= dcnt - 3'd1;
  assign dp_w = (dcnt == 3'd0) || (dcnt == 3'd4);

  always @(posedge clk) begin
    if (dp_start) nstart++;
    if (mem_rd) nrd++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_ir(input string tag);
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk(tag, {16'd0, ir}, {16'd0, e});
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dp_start && n < 50);
    chk({tag, "_start"}, {31'd0, dp_start}, 32'd1);
    pop_ir({tag, "_ir"});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) prog[i] = 16'hA000;
    prog[0]   = 16'hD105;
    prog[511] = 16'hD105;
    // reset with run high, then release and catch the first fetch
    reset_n = 1'b0;
    run = 1'b1;
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_dp_start", {31'd0, dp_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", {23'd0, pc}, 32'd0);
    chk("rst_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    chk("rst_wrap_pc", {23'd0, w_pc}, 32'd511);
    reset_n = 1'b1;
    chk("rel_mem_rd0", {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    chk("rel_mem_rd1", {31'd0, mem_rd}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd1);
    // asynchronous reset while stalled in FETCH
    #2 reset_n = 1'b0;
    #1;
    chk("async_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    run = 1'b0;
    rdy = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", {31'd0, mem_rd}, 32'd0);
    // single instruction, zero-wait memory, run pulsed for one cycle
    s0 = nstart;
    exp_q.push_back(16'hD105);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("one_fetch", {31'd0, mem_rd}, 32'd1);
    @(negedge clk);
    chk("one_issue", {31'd0, dp_start}, 32'd1);
    pop_ir("one_ir");
    chk("one_pc_pre", {23'd0, pc}, 32'd0);
    @(negedge clk);
    chk("one_pulse_end", {31'd0, dp_start}, 32'd0);
    chk("one_pc", {23'd0, pc}, 32'd1);
    chk("wrap_pc", {23'd0, w_pc}, 32'd0);
    wait_idle("one_idle");
    chk("one_count", {16'd0, instr_count}, 32'd1);
    chk("one_nstart", nstart - s0, 32'd1);
    chk("one_ir_hold", {16'd0, ir}, 32'h0000_D105);
    // three memory wait cycles
    rdy = 1'b0;
    prog[1] = 16'hA000;
    exp_q.push_back(16'hA000);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("wrap_addr", {23'd0, w_addr}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rdy = 1'b1;
      chk("ws_mem_rd", {31'd0, mem_rd}, 32'd1);
      chk("ws_addr", {23'd0, mem_addr}, 32'd1);
      chk("ws_no_start", {31'd0, dp_start}, 32'd0);
      @(negedge clk);
    end
    chk("ws_start", {31'd0, dp_start}, 32'd1);
    pop_ir("ws_ir");
    wait_idle("ws_idle");
    chk("ws_count", {16'd0, instr_count}, 32'd2);
    chk("ws_pc", {23'd0, pc}, 32'd2);
    // run dropped in ACK: instruction still retires
    prog[2] = 16'hA800;
    exp_q.push_back(16'hA800);
    run = 1'b1;
    wait_start("stop");
    @(negedge clk);
    run = 1'b0;
    chk("stop_busy", {31'd0, busy}, 32'd1);
    wait_idle("stop_idle");
    chk("stop_count", {16'd0, instr_count}, 32'd3);
    chk("stop_pc", {23'd0, pc}, 32'd3);
    repeat (3) @(negedge clk);
    chk("stop_no_rd", {31'd0, mem_rd}, 32'd0);
    // HALT after two ALU instructions with run held high
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    prog[0] = 16'hA123;
    prog[1] = 16'hB456;
    prog[2] = 16'hE000;
    exp_q.push_back(16'hA123);
    exp_q.push_back(16'hB456);
    run = 1'b1;
    wait_start("halt_i0");
    wait_start("halt_i1");
    for (int n = 0; n < 50 && !halted; n++) @(negedge clk);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_count", {16'd0, instr_count}, 32'd2);
    chk("halt_pc", {23'd0, pc}, 32'd2);
    chk("halt_ir", {16'd0, ir}, 32'h0000_E000);
    chk("halt_busy", {31'd0, busy}, 32'd0);
    s0 = nstart;
    r0 = nrd;
    repeat (20) @(negedge clk);
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_no_start", nstart - s0, 32'd0);
    chk("halt_no_rd", nrd - r0, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
